pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl_stall_counter.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the mul/div timeout limit and counter widths.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  // Mul/div timeout: limit value and the width of the counter that reaches it
  localparam int MD_TIMEOUT = 63;
  localparam int TMO_W      = 6;

  // Width of the saturating stall-cycle counter
  localparam int STALLCNT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: pipeline status in, write enables / flushes / status out.
// master = pipeline side (drives status), slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Pipeline status towards the controller
  logic                  IDEX_MemRd;
  logic [4:0]            IDEX_Rt;
  logic [4:0]            IFID_Rs;
  logic [4:0]            IFID_Rt;
  logic                  EX_BranchTaken;
  logic                  ID_Jump;
  logic                  IDEX_MDStart;
  logic                  MD_Done;
  logic                  Cnt_Clr;

  // Controller decisions towards the pipeline
  logic                  PC_Wr;
  logic                  IFID_Wr;
  logic                  IDEX_Wr;
  logic                  IFID_Flush;
  logic                  IDEX_Flush;
  logic                  EXMEM_Flush;
  logic                  MD_Timeout;
  logic [STALLCNT_W-1:0] StallCnt;

  modport master (
    output IDEX_MemRd, IDEX_Rt, IFID_Rs, IFID_Rt, EX_BranchTaken, ID_Jump,
           IDEX_MDStart, MD_Done, Cnt_Clr,
    input  PC_Wr, IFID_Wr, IDEX_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MD_Timeout, StallCnt
  );

  modport slave (
    input  IDEX_MemRd, IDEX_Rt, IFID_Rs, IFID_Rt, EX_BranchTaken, ID_Jump,
           IDEX_MDStart, MD_Done, Cnt_Clr,
    output PC_Wr, IFID_Wr, IDEX_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MD_Timeout, StallCnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_stall_counter.sv
// Saturating up-counter of stalled cycles; clear beats increment.
// Count updates one edge after inc/clr; holds at all-ones instead of wrapping.
module pipe_stall_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = STALLCNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, mul/div stall.
// Enables/flushes are combinational from the current inputs and state.
// Mul/div stall FSM and timeout exist only when PIPE_MD_STALL_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  logic md_busy;
  logic md_timeout;
  logic load_use;
  logic pc_wr;
  logic ifid_wr;
  logic idex_wr;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic [STALLCNT_W-1:0] stall_cnt;

  assign load_use = bus.IDEX_MemRd && (bus.IDEX_Rt != 5'd0) &&
                    ((bus.IDEX_Rt == bus.IFID_Rs) || (bus.IDEX_Rt == bus.IFID_Rt));

`ifdef PIPE_MD_STALL_EN
  state_e           state_q;
  state_e           state_d;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic             tmo_fire;
  logic             md_timeout_q;

  // Next state and timeout counter; MD_Done beats a timeout in the same cycle,
  // and a start seen while finishing is dropped because the FSM is not in RUN
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_fire  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.IDEX_MDStart) begin
          state_d   = MD_BUSY;
          tmo_cnt_d = '0;
        end
      end
      MD_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (bus.MD_Done) begin
          state_d = RUN;
        end else if (tmo_cnt_q == TMO_W'(MD_TIMEOUT - 1)) begin
          tmo_fire = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, timeout counter and registered timeout pulse; reset drops any op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      tmo_cnt_q    <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      md_timeout_q <= tmo_fire;
    end
  end

  assign md_busy    = (state_q == MD_BUSY);
  assign md_timeout = md_timeout_q;
`else
  // Mul/div stall compiled out: controller is permanently in RUN
  logic unused_md;
  assign unused_md  = bus.IDEX_MDStart ^ bus.MD_Done;
  assign md_busy    = 1'b0;
  assign md_timeout = 1'b0;
`endif

  // Hazard priority: reset > mul/div busy > branch > load-use > jump
  always_comb begin
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    idex_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (reset) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_wr = 1'b0;
    end else if (md_busy) begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      idex_wr     = 1'b0;
      exmem_flush = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
    end else if (bus.ID_Jump) begin
      ifid_flush = 1'b1;
    end
  end

  pipe_stall_counter #(
    .W (STALLCNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_wr),
    .clr   (bus.Cnt_Clr),
    .count (stall_cnt)
  );

  assign bus.PC_Wr       = pc_wr;
  assign bus.IFID_Wr     = ifid_wr;
  assign bus.IDEX_Wr     = idex_wr;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Flush  = idex_flush;
  assign bus.EXMEM_Flush = exmem_flush;
  assign bus.MD_Timeout  = md_timeout;
  assign bus.StallCnt    = stall_cnt;

endmodule
